// File: rtl/avalon_pixel_writer_pkg.sv
// Shared definitions for the Avalon pixel writer: FSM state encoding and
// helpers that size the scan counters, including degenerate one-wide frames.
package avalon_pixel_writer_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_PIX = 2'd1,
        WRITE    = 2'd2,
        DONE     = 2'd3
    } state_t;

    // A one-position axis still needs a 1-bit counter, since $clog2(1) is 0.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_ROWS = 4;
    localparam int DEF_COLS = 4;
    localparam int X_W      = cnt_width(DEF_ROWS);
    localparam int Y_W      = cnt_width(DEF_COLS);

endpackage

// File: rtl/avalon_pixel_writer_if.sv
// Bundles the pixel stream, frame control and Avalon-MM write bus of the
// pixel writer. The writer drives the master side.
interface avalon_pixel_writer_if
    import avalon_pixel_writer_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 32,
    parameter int X_BITS = X_W,
    parameter int Y_BITS = Y_W
);
    logic              start_i;
    logic [ADDR_W-1:0] base_addr_i;
    logic [DATA_W-1:0] pix_data_i;
    logic              pix_valid_i;
    logic              pix_ready_o;
    logic [ADDR_W-1:0] avm_address_o;
    logic              avm_write_o;
    logic [DATA_W-1:0] avm_writedata_o;
    logic              avm_waitrequest_i;
    logic [X_BITS-1:0] x_o;
    logic [Y_BITS-1:0] y_o;
    logic              busy_o;
    logic              done_o;

    modport master (
        input  start_i, base_addr_i, pix_data_i, pix_valid_i, avm_waitrequest_i,
        output pix_ready_o, avm_address_o, avm_write_o, avm_writedata_o,
        output x_o, y_o, busy_o, done_o
    );

    modport slave (
        output start_i, base_addr_i, pix_data_i, pix_valid_i, avm_waitrequest_i,
        input  pix_ready_o, avm_address_o, avm_write_o, avm_writedata_o,
        input  x_o, y_o, busy_o, done_o
    );

endinterface

// File: rtl/avalon_pixel_writer_pixel_scan_counter.sv
// Frame scan position counter: Y is the fast axis, X the slow one, and both
// wrap to zero after the last position of the frame.
module pixel_scan_counter
    import avalon_pixel_writer_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    localparam int X_BITS = cnt_width(ROWS),
    localparam int Y_BITS = cnt_width(COLS)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_inc,
    input  logic              i_clear,
    output logic [X_BITS-1:0] o_x,
    output logic [Y_BITS-1:0] o_y,
    output logic              o_last
);

    logic [X_BITS-1:0] r_x;
    logic [Y_BITS-1:0] r_y;
    logic              w_x_end;
    logic              w_y_end;

    assign w_x_end = (r_x == X_BITS'(ROWS - 1));
    assign w_y_end = (r_y == Y_BITS'(COLS - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_clear) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_inc) begin
            if (w_y_end) begin
                r_y <= '0;
                r_x <= w_x_end ? '0 : r_x + 1'b1;
            end else begin
                r_y <= r_y + 1'b1;
            end
        end
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_last = w_x_end && w_y_end;

endmodule

// File: rtl/avalon_pixel_writer.sv
// Avalon-MM write master that stores each incoming filtered pixel at the
// address of its scan position and reports frame completion.
module avalon_pixel_writer
    import avalon_pixel_writer_pkg::*;
#(
    parameter int ROWS          = 4,
    parameter int COLS          = 4,
    parameter int DATA_W        = 8,
    parameter int ADDR_W        = 32,
    parameter int BYTES_PER_PIX = 1,
    localparam int X_BITS = cnt_width(ROWS),
    localparam int Y_BITS = cnt_width(COLS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    avalon_pixel_writer_if.master bus
);

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [ADDR_W-1:0] w_offset;
    logic [X_BITS-1:0] w_x;
    logic [Y_BITS-1:0] w_y;
    logic              w_last;
    logic              w_start;
    logic              w_accept;
    logic              w_inc;

    pixel_scan_counter #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_scan (
        .i_clk   (clk_i),
        .i_rst_n (rst_i),
        .i_inc   (w_inc),
        .i_clear (w_start),
        .o_x     (w_x),
        .o_y     (w_y),
        .o_last  (w_last)
    );

    // Linear pixel index scaled to bytes; everything stays in ADDR_W bits so
    // the final sum wraps modulo 2^ADDR_W.
    assign w_offset = (ADDR_W'(w_x) * ADDR_W'(COLS) + ADDR_W'(w_y))
                      * ADDR_W'(BYTES_PER_PIX);

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_accept     = 1'b0;
        w_inc        = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start_i) begin
                    w_start      = 1'b1;
                    w_state_next = WAIT_PIX;
                end
            end
            WAIT_PIX: begin
                if (bus.pix_valid_i) begin
                    w_accept     = 1'b1;
                    w_state_next = WRITE;
                end
            end
            WRITE: begin
                if (!bus.avm_waitrequest_i) begin
                    w_inc        = 1'b1;
                    w_state_next = w_last ? DONE : WAIT_PIX;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_base  <= '0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_base <= bus.base_addr_i;
            end
            if (w_accept) begin
                r_addr <= r_base + w_offset;
                r_data <= bus.pix_data_i;
            end
        end
    end

    // Decoded straight from the state register so reset kills the write at once.
    assign bus.pix_ready_o     = (r_state == WAIT_PIX);
    assign bus.avm_write_o     = (r_state == WRITE);
    assign bus.busy_o          = (r_state != IDLE);
    assign bus.done_o          = (r_state == DONE);
    assign bus.avm_address_o   = r_addr;
    assign bus.avm_writedata_o = r_data;
    assign bus.x_o             = w_x;
    assign bus.y_o             = w_y;

endmodule

// File: doc/avalon_pixel_writer.md
Name: avalon_pixel_writer

Overview:
- Avalon-MM write master at the output end of the edge-detection datapath.
- Accepts filtered pixels over a valid/ready stream and writes each pixel to memory at the address of its (X,Y) position in the frame.
- Walks the frame in scan order (Y inner, X outer) and signals frame completion to the top-level controller.

Parameters:
ROWS, 4, number of X positions per frame (X runs 0..ROWS-1)
COLS, 4, number of Y positions per row (Y runs 0..COLS-1)
DATA_W, 8, pixel / Avalon writedata width in bits
ADDR_W, 32, Avalon address width in bits
BYTES_PER_PIX, 1, address increment per pixel

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, asynchronous, active-low
start_i  in  1  single-cycle frame start request
base_addr_i  in  ADDR_W  frame base address, sampled on accepted start_i
pix_data_i  in  DATA_W  filtered pixel
pix_valid_i  in  1  pixel valid
pix_ready_o  out  1  writer can accept a pixel
avm_address_o  out  ADDR_W  Avalon-MM address
avm_write_o  out  1  Avalon-MM write request
avm_writedata_o  out  DATA_W  Avalon-MM write data
avm_waitrequest_i  in  1  Avalon-MM slave stall
x_o  out  $clog2(ROWS)  current X position
y_o  out  $clog2(COLS)  current Y position
busy_o  out  1  frame in progress
done_o  out  1  one-cycle pulse after the last write completes

Behaviour:
- Reset (rst_i low, asynchronous): state IDLE; all outputs, counters and the base register go to 0; avm_write_o drops immediately, even mid-transfer. The partial frame is abandoned and there is no resume.
- FSM states: IDLE, WAIT_PIX, WRITE, DONE.
- IDLE:
  - busy_o=0, pix_ready_o=0.
  - start_i=1 → latch base_addr_i, clear X/Y to 0, go to WAIT_PIX.
- WAIT_PIX:
  - busy_o=1, pix_ready_o=1, avm_write_o=0.
  - pix_valid_i&pix_ready_o at edge N → register pix_data_i and address, go to WRITE. avm_write_o=1 from cycle N+1.
- WRITE:
  - avm_write_o=1, pix_ready_o=0.
  - address and writedata are held stable while avm_waitrequest_i=1.
  - The transfer completes on the first edge with avm_waitrequest_i=0.
  - On completion, if X=ROWS-1 and Y=COLS-1 → go to DONE and clear X/Y to 0.
  - Otherwise increment scan position and return to WAIT_PIX.
- Scan order:
  - Y increments.
  - At Y=COLS-1, Y wraps to 0 and X increments.
  - At X=ROWS-1 and Y=COLS-1, both wrap to 0.
- DONE: done_o=1 for exactly one cycle, busy_o=1, then go to IDLE.
- Address: avm_address_o = base + (X*COLS + Y)*BYTES_PER_PIX, computed in ADDR_W bits, wrapping modulo 2^ADDR_W.
- Throughput: minimum 2 cycles per pixel (accept, write) with waitrequest low. Each waitrequest cycle adds one cycle.
- Ignored events:
  - start_i is ignored outside IDLE.
  - pix_valid_i is ignored when pix_ready_o=0; the source holds data until ready.
  - start_i in the same cycle as done_o is ignored (FSM is in DONE, not IDLE).
- x_o/y_o show the position of the pixel being accepted or written. They read 0 in IDLE.
- ROWS=1 or COLS=1 is legal; the counter width is then forced to a minimum of 1 bit.

Decomposition:
- Shared package holds:
  - FSM state encoding (2-bit localparams IDLE/WAIT_PIX/WRITE/DONE);
  - width helper localparams X_W=max(1,$clog2(ROWS)) and Y_W=max(1,$clog2(COLS)).
- One sub-module: pixel_scan_counter.
  - Inputs: inc, clear. Outputs: X, Y, last.
  - Same async active-low reset as the parent.
- avalon_pixel_writer instantiates it and owns the FSM, the address multiply-add and the Avalon registers.

Test Plan:
- Reset idle: rst_i low, then high → all outputs 0, pix_ready_o=0; start_i with base 0x1000 → busy_o=1 and pix_ready_o=1 next cycle.
- Full frame with ROWS=COLS=4, BYTES_PER_PIX=1, base 0x1000, waitrequest tied 0, pixels 0..15 → 16 writes to addresses 0x1000..0x100F with writedata equal to pixel index, 2 cycles each. done_o pulses once, 1 cycle after the 16th write.
- Waitrequest stall: hold avm_waitrequest_i=1 for 3 cycles on pixel 5 → address 0x1005 and data 5 stay stable with avm_write_o=1; pix_ready_o=0 throughout; the next pixel is accepted only after the stall releases.
- Ignored inputs: pix_valid_i pulses in IDLE and during WRITE → no writes, no counter movement. start_i during busy → base unchanged, frame continues.
- Reset mid-write: drop rst_i during the WRITE of pixel 7 → avm_write_o=0 immediately. After release, a new start_i with base 0x2000 writes the first pixel to 0x2000.
- Address wrap: base 0xFFFFFFFE, BYTES_PER_PIX=2 → pixels 0, 1, 2 go to 0xFFFFFFFE, 0x00000000 and 0x00000002.
